// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one behavioural_alu between two requesters (A and B).
// A request is granted in IDLE, its operands are registered and shown to the
// ALU for one EXEC cycle, and the ALU result and flags are captured into a
// response register. That register is offered to the owning port until the
// port consumes it.
//
// Parameters: DATA_W operand/result width, OP_W op_code width.
// Ports:
//   clk, rstb                       clock, async active-low reset
//   {a,b}_req_valid/_ready          request handshake per port
//   {a,b}_req_x/_y/_op              request operands and op_code
//   {a,b}_rsp_valid/_ready          response handshake per port
//   rsp_z, rsp_zero/_overflow/_equal captured result and flags (shared)
//   alu_x, alu_y, alu_op            registered operands to the ALU
//   alu_z, alu_zero/_overflow/_equal ALU result and flags
//
// Build option: define ALU_ARB_RR_EN for round-robin tie-breaking; without it
// port A has fixed priority.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no operation outstanding; arbitrate and accept one request
// EXEC  | ALU evaluates the registered operands; capture at cycle end
// RESP  | response offered to the owner until its rsp_ready is high

module alu_arbiter #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              a_req_valid,
    output logic              a_req_ready,
    input  logic [DATA_W-1:0] a_req_x,
    input  logic [DATA_W-1:0] a_req_y,
    input  logic [OP_W-1:0]   a_req_op,
    input  logic              b_req_valid,
    output logic              b_req_ready,
    input  logic [DATA_W-1:0] b_req_x,
    input  logic [DATA_W-1:0] b_req_y,
    input  logic [OP_W-1:0]   b_req_op,
    output logic              a_rsp_valid,
    input  logic              a_rsp_ready,
    output logic              b_rsp_valid,
    input  logic              b_rsp_ready,
    output logic [DATA_W-1:0] rsp_z,
    output logic              rsp_zero,
    output logic              rsp_overflow,
    output logic              rsp_equal,
    output logic [DATA_W-1:0] alu_x,
    output logic [DATA_W-1:0] alu_y,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_z,
    input  logic              alu_zero,
    input  logic              alu_overflow,
    input  logic              alu_equal
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] x_q, y_q, z_q;
    logic [OP_W-1:0]   op_q;
    logic              owner_q;   // 0 = port A, 1 = port B
    logic              zero_q, ovf_q, eq_q;
    logic              grant_a, grant_b;
    logic              handshake;
    logic              owner_rsp_ready;

`ifdef ALU_ARB_RR_EN
    // Last-grant pointer: 1 means B was granted last, so A wins the next tie.
    logic last_q;

    always_comb begin
        grant_a = a_req_valid && (!b_req_valid || last_q);
        grant_b = b_req_valid && (!a_req_valid || !last_q);
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            last_q <= 1'b1;
        end else if (handshake) begin
            last_q <= b_req_ready;
        end
    end
`else
    always_comb begin
        grant_a = a_req_valid;
        grant_b = b_req_valid && !a_req_valid;
    end
`endif

    always_comb begin
        a_req_ready = (state_q == IDLE) && grant_a;
        b_req_ready = (state_q == IDLE) && grant_b;
        handshake   = a_req_ready || b_req_ready;
        owner_rsp_ready = owner_q ? b_rsp_ready : a_rsp_ready;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (handshake) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (owner_rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            x_q     <= '0;
            y_q     <= '0;
            op_q    <= '0;
            owner_q <= 1'b0;
            z_q     <= '0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
            eq_q    <= 1'b0;
        end else begin
            if (handshake) begin
                x_q     <= b_req_ready ? b_req_x  : a_req_x;
                y_q     <= b_req_ready ? b_req_y  : a_req_y;
                op_q    <= b_req_ready ? b_req_op : a_req_op;
                owner_q <= b_req_ready;
            end
            if (state_q == EXEC) begin
                z_q    <= alu_z;
                zero_q <= alu_zero;
                ovf_q  <= alu_overflow;
                eq_q   <= alu_equal;
            end
        end
    end

    always_comb begin
        a_rsp_valid  = (state_q == RESP) && !owner_q;
        b_rsp_valid  = (state_q == RESP) &&  owner_q;
        rsp_z        = z_q;
        rsp_zero     = zero_q;
        rsp_overflow = ovf_q;
        rsp_equal    = eq_q;
        alu_x        = x_q;
        alu_y        = y_q;
        alu_op       = op_q;
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU model attached
// to the alu_* ports. Op-code values below stand in for the OP_* encodings.
module tb_alu_arbiter;

    localparam int DW = 32;
    localparam int OW = 4;
    localparam logic [OW-1:0] OP_AND = 4'h0;
    localparam logic [OW-1:0] OP_OR  = 4'h1;
    localparam logic [OW-1:0] OP_XOR = 4'h2;
    localparam logic [OW-1:0] OP_ADD = 4'h3;
    localparam logic [OW-1:0] OP_SUB = 4'h4;

    logic          clk = 1'b0;
    logic          rstb;
    logic          a_req_valid, b_req_valid, a_req_ready, b_req_ready;
    logic [DW-1:0] a_req_x, a_req_y, b_req_x, b_req_y;
    logic [OW-1:0] a_req_op, b_req_op;
    logic          a_rsp_valid, b_rsp_valid, a_rsp_ready, b_rsp_ready;
    logic [DW-1:0] rsp_z;
    logic          rsp_zero, rsp_overflow, rsp_equal;
    logic [DW-1:0] alu_x, alu_y, alu_z;
    logic [OW-1:0] alu_op;
    logic          alu_zero, alu_overflow, alu_equal;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.DATA_W(DW), .OP_W(OW)) dut (
        .clk(clk), .rstb(rstb),
        .a_req_valid(a_req_valid), .a_req_ready(a_req_ready),
        .a_req_x(a_req_x), .a_req_y(a_req_y), .a_req_op(a_req_op),
        .b_req_valid(b_req_valid), .b_req_ready(b_req_ready),
        .b_req_x(b_req_x), .b_req_y(b_req_y), .b_req_op(b_req_op),
        .a_rsp_valid(a_rsp_valid), .a_rsp_ready(a_rsp_ready),
        .b_rsp_valid(b_rsp_valid), .b_rsp_ready(b_rsp_ready),
        .rsp_z(rsp_z), .rsp_zero(rsp_zero), .rsp_overflow(rsp_overflow),
        .rsp_equal(rsp_equal),
        .alu_x(alu_x), .alu_y(alu_y), .alu_op(alu_op),
        .alu_z(alu_z), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
        .alu_equal(alu_equal)
    );

    // Behavioural ALU
    always_comb begin
        alu_z        = '0;
        alu_overflow = 1'b0;
        case (alu_op)
            OP_AND: alu_z = alu_x & alu_y;
            OP_OR:  alu_z = alu_x | alu_y;
            OP_XOR: alu_z = alu_x ^ alu_y;
            OP_ADD: begin
                alu_z        = alu_x + alu_y;
                alu_overflow = (alu_x[DW-1] == alu_y[DW-1]) && (alu_z[DW-1] != alu_x[DW-1]);
            end
            OP_SUB: begin
                alu_z        = alu_x - alu_y;
                alu_overflow = (alu_x[DW-1] != alu_y[DW-1]) && (alu_z[DW-1] != alu_x[DW-1]);
            end
            default: alu_z = '0;
        endcase
        alu_zero  = (alu_z == '0);
        alu_equal = (alu_x == alu_y);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One complete single-port transaction with rsp_ready given in the first RESP cycle.
    task automatic run_op(input string tag, input bit pb,
                          input logic [DW-1:0] x, input logic [DW-1:0] y,
                          input logic [OW-1:0] op,
                          input logic [DW-1:0] exp_z, input logic [2:0] exp_flags);
        @(negedge clk);
        if (pb) begin
            b_req_valid = 1'b1; b_req_x = x; b_req_y = y; b_req_op = op;
        end else begin
            a_req_valid = 1'b1; a_req_x = x; a_req_y = y; a_req_op = op;
        end
        #1;
        chk({tag, "_rdy_own"},   pb ? b_req_ready : a_req_ready, 1);
        chk({tag, "_rdy_other"}, pb ? a_req_ready : b_req_ready, 0);
        @(negedge clk);
        a_req_valid = 1'b0; b_req_valid = 1'b0;
        #1;
        chk({tag, "_exec_rdy"},  {a_req_ready, b_req_ready}, 0);
        chk({tag, "_exec_vld"},  {a_rsp_valid, b_rsp_valid}, 0);
        chk({tag, "_alu_x"},     alu_x, x);
        chk({tag, "_alu_op"},    alu_op, op);
        @(negedge clk); #1;
        chk({tag, "_rsp_vld"},   {a_rsp_valid, b_rsp_valid}, pb ? 2'b01 : 2'b10);
        chk({tag, "_rsp_z"},     rsp_z, exp_z);
        chk({tag, "_flags"},     {rsp_zero, rsp_overflow, rsp_equal}, exp_flags);
        if (pb) b_rsp_ready = 1'b1; else a_rsp_ready = 1'b1;
        @(negedge clk); #1;
        chk({tag, "_idle_vld"},  {a_rsp_valid, b_rsp_valid}, 0);
        a_rsp_ready = 1'b0; b_rsp_ready = 1'b0;
    endtask

    initial begin
        bit exp_a;
        logic [DW-1:0] exp_z;

        rstb = 1'b0;
        a_req_valid = 0; a_req_x = '0; a_req_y = '0; a_req_op = '0;
        b_req_valid = 0; b_req_x = '0; b_req_y = '0; b_req_op = '0;
        a_rsp_ready = 0; b_rsp_ready = 0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req_rdy", {a_req_ready, b_req_ready}, 0);
        chk("rst_rsp_vld", {a_rsp_valid, b_rsp_valid}, 0);
        chk("rst_rsp_z",   rsp_z, 0);
        chk("rst_flags",   {rsp_zero, rsp_overflow, rsp_equal}, 0);
        chk("rst_alu",     {alu_x, alu_y, alu_op}, 0);
        rstb = 1'b1;

        // Port A: 5 + 7
        run_op("a_add", 1'b0, 32'd5, 32'd7, OP_ADD, 32'd12, 3'b000);
        // Operand registers hold outside EXEC
        chk("hold_alu_y", alu_y, 32'd7);

        // Port B: signed overflow, then equal operands subtract to zero
        run_op("b_ovf", 1'b1, 32'h7FFF_FFFF, 32'd1, OP_ADD, 32'h8000_0000, 3'b010);
        run_op("b_sub", 1'b1, 32'd9, 32'd9, OP_SUB, 32'd0, 3'b101);

        // Backpressure: A holds rsp_ready low for 10 RESP cycles while B waits
        @(negedge clk);
        a_req_valid = 1; a_req_x = 32'd6; a_req_y = 32'd3; a_req_op = OP_AND;
        #1;
        chk("bp_a_rdy", a_req_ready, 1);
        @(negedge clk);
        a_req_valid = 0;
        b_req_valid = 1; b_req_x = 32'd3; b_req_y = 32'd1; b_req_op = OP_XOR;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("bp_vld",   {a_rsp_valid, b_rsp_valid}, 2'b10);
            chk("bp_z",     rsp_z, 32'd2);
            chk("bp_flags", {rsp_zero, rsp_overflow, rsp_equal}, 3'b000);
            chk("bp_rdy",   {a_req_ready, b_req_ready}, 0);
            @(negedge clk);
        end
        a_rsp_ready = 1;
        @(negedge clk); #1;
        chk("bp_rel_vld",  {a_rsp_valid, b_rsp_valid}, 0);
        chk("bp_rel_brdy", b_req_ready, 1);
        a_rsp_ready = 0;
        @(negedge clk);
        b_req_valid = 0;
        @(negedge clk); #1;
        chk("bp_b_vld", {a_rsp_valid, b_rsp_valid}, 2'b01);
        chk("bp_b_z",   rsp_z, 32'd2);
        b_rsp_ready = 1;
        @(negedge clk); #1;
        b_rsp_ready = 0;

        // Reset while in EXEC discards the operation
        @(negedge clk);
        a_req_valid = 1; a_req_x = 32'd3; a_req_y = 32'd4; a_req_op = OP_ADD;
        @(negedge clk);
        a_req_valid = 0;
        rstb = 1'b0;
        #1;
        chk("rexec_vld",   {a_rsp_valid, b_rsp_valid}, 0);
        chk("rexec_z",     rsp_z, 0);
        chk("rexec_alu",   {alu_x, alu_y, alu_op}, 0);
        a_rsp_ready = 1;
        @(negedge clk); #1;
        chk("rexec_vld2",  {a_rsp_valid, b_rsp_valid}, 0);
        a_rsp_ready = 0;
        rstb = 1'b1;
        run_op("post_rst", 1'b0, 32'd3, 32'd4, OP_ADD, 32'd7, 3'b000);

        // Unknown op_code
        run_op("unk_op", 1'b0, 32'd1, 32'd1, 4'hF, 32'd0, 3'b101);

        // Both ports valid continuously, from a fresh reset
        @(negedge clk);
        rstb = 1'b0;
        @(negedge clk);
        rstb = 1'b1;
        a_req_x = 32'd1; a_req_y = 32'd2; a_req_op = OP_OR;
        b_req_x = 32'd3; b_req_y = 32'd1; b_req_op = OP_XOR;
        a_rsp_ready = 1; b_rsp_ready = 1;
        for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_RR_EN
            exp_a = (i % 2 == 0);
`else
            exp_a = 1'b1;
`endif
            exp_z = exp_a ? 32'd3 : 32'd2;
            @(negedge clk);
            a_req_valid = 1; b_req_valid = 1;
            #1;
            chk("tie_grant", {a_req_ready, b_req_ready}, exp_a ? 2'b10 : 2'b01);
            @(negedge clk);
            @(negedge clk); #1;
            chk("tie_owner", {a_rsp_valid, b_rsp_valid}, exp_a ? 2'b10 : 2'b01);
            chk("tie_z",     rsp_z, exp_z);
        end
        a_req_valid = 0; b_req_valid = 0;
        a_rsp_ready = 0; b_rsp_ready = 0;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
